// File: rtl/ser_8b10b_tx.sv
// ---------------------------------------------------------------------------
// ser_8b10b_tx
//
// 8b/10b encoder and serializer. A byte (data or K character) is accepted
// on a valid/ready handshake once per 10-bit symbol. It is encoded with
// running disparity using the IEEE 802.3 clause 36 tables. The symbol is then
// shifted out one bit per clock, bit 'a' first. If no word is offered at a
// symbol boundary, IDLE_K (K28.5 by default) is sent as fill, so the link
// never idles.
//
// Parameters:
//   IDLE_K     fill control character (must be a valid K code)
//   SYM_W      symbol width, fixed at 10 (only sizes the bit counter)
//
// Ports:
//   clk        transmit bit clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_8b      data byte HGFEDCBA
//   in_k       1 = in_8b is a control character
//   in_valid   word offered
//   in_ready   word accepted when in_valid & in_ready (1 cycle in 10)
//   ser_out    serial line, bit 'a' of each symbol first
//   sym_start  high while ser_out carries bit 'a'
//   rd_out     running disparity after the current symbol (0 = RD-, 1 = RD+)
//   code_err   pulse with sym_start when an invalid K code was accepted
//
// Optional feature, enabled by defining SER_PRBS7_EN:
//   prbs_mode  1 = ser_out carries raw PRBS7 (x^7 + x^6 + 1) and bypasses
//              the encoder. While it is set, no word is accepted, sym_start
//              stays low and running disparity is frozen. Normal symbols
//              resume at the next symbol boundary.
// ---------------------------------------------------------------------------
module ser_8b10b_tx #(
    parameter logic [7:0]  IDLE_K = 8'hBC,
    parameter int unsigned SYM_W  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_8b,
    input  logic       in_k,
    input  logic       in_valid,
`ifdef SER_PRBS7_EN
    input  logic       prbs_mode,
`endif
    output logic       in_ready,
    output logic       ser_out,
    output logic       sym_start,
    output logic       rd_out,
    output logic       code_err
);

    localparam int unsigned     CntW    = $clog2(SYM_W);
    localparam logic [CntW-1:0] LastBit = CntW'(SYM_W - 1);

    // ------------------------------------------------------------------
    // Code tables. Each table holds the RD- form and is written MSB-first
    // as abcdei / fghj. The RD+ form is the complement where applicable.
    // ------------------------------------------------------------------
    function automatic logic [5:0] enc6(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:  c = 6'b100111;
            5'd1:  c = 6'b011101;
            5'd2:  c = 6'b101101;
            5'd3:  c = 6'b110001;
            5'd4:  c = 6'b110101;
            5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;
            5'd7:  c = 6'b111000;
            5'd8:  c = 6'b111001;
            5'd9:  c = 6'b100101;
            5'd10: c = 6'b010101;
            5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;
            5'd13: c = 6'b101100;
            5'd14: c = 6'b011100;
            5'd15: c = 6'b010111;
            5'd16: c = 6'b011011;
            5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;
            5'd19: c = 6'b110010;
            5'd20: c = 6'b001011;
            5'd21: c = 6'b101010;
            5'd22: c = 6'b011010;
            5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;
            5'd25: c = 6'b100110;
            5'd26: c = 6'b010110;
            5'd27: c = 6'b110110;
            5'd28: c = 6'b001110;
            5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;
            default: c = 6'b101011; // D.31
        endcase
        return c;
    endfunction

    function automatic logic [3:0] enc4_d(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0: c = 4'b1011;
            3'd1: c = 4'b1001;
            3'd2: c = 4'b0101;
            3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;
            3'd5: c = 4'b1010;
            3'd6: c = 4'b0110;
            default: c = 4'b1110; // D.x.P7
        endcase
        return c;
    endfunction

    // K sub-blocks are always complemented under RD+, including the
    // balanced ones, so that commas keep their pattern.
    function automatic logic [3:0] enc4_k(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0: c = 4'b1011;
            3'd1: c = 4'b0110;
            3'd2: c = 4'b1010;
            3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;
            3'd5: c = 4'b0101;
            3'd6: c = 4'b1001;
            default: c = 4'b0111;
        endcase
        return c;
    endfunction

    // K28.0-K28.7 and K23.7, K27.7, K29.7, K30.7.
    function automatic logic k_is_valid(input logic [7:0] b);
        logic [4:0] x;
        x = b[4:0];
        return (x == 5'd28) ||
               ((b[7:5] == 3'd7) &&
                ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [8:0]      shift_q, shift_d;
    logic            ser_q, ser_d;
    logic            start_q, start_d;
    logic            rd_q, rd_d;
    logic            err_q, err_d;
`ifdef SER_PRBS7_EN
    logic [6:0]      prbs_q, prbs_d;
    logic            prbs_fb;
`endif

    logic boundary;
    assign boundary = (bit_cnt_q == LastBit);

`ifdef SER_PRBS7_EN
    assign in_ready = rst_n & boundary & ~prbs_mode;
`else
    assign in_ready = rst_n & boundary;
`endif

    // ------------------------------------------------------------------
    // Symbol source selection and encoding
    // ------------------------------------------------------------------
    logic       accept;
    logic       src_k;
    logic [7:0] src_byte;
    logic       bad_k;
    logic [4:0] x5;
    logic [2:0] y3;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       unbal6, unbal4;
    logic       rd6;
    logic       alt7;
    logic       rd_sym;
    logic [9:0] sym_msb;  // abcdeifghj, 'a' in bit 9
    logic [9:0] sym;      // transmit order, 'a' in bit 0

    always_comb begin
        accept   = in_valid & in_ready;
        src_k    = 1'b1;
        src_byte = IDLE_K;
        bad_k    = 1'b0;
        if (accept) begin
            src_k    = in_k;
            src_byte = in_8b;
            bad_k    = in_k & ~k_is_valid(in_8b);
        end
        // An invalid K is still consumed; K28.5 goes out in its place.
        if (bad_k) begin
            src_byte = 8'hBC;
        end
        x5 = src_byte[4:0];
        y3 = src_byte[7:5];

        // 5b/6b. D.07 is balanced but still has distinct RD-/RD+ forms.
        c6     = (src_k && (x5 == 5'd28)) ? 6'b001111 : enc6(x5);
        unbal6 = ($countones(c6) != 3);
        if (rd_q && (unbal6 || (!src_k && (x5 == 5'd7)))) begin
            c6 = ~c6;
        end
        rd6 = rd_q ^ unbal6;

        // 3b/4b, selected by the disparity left after the 6b sub-block.
        // A7 avoids a run of five equal bits across the sub-block seam.
        alt7 = !src_k && (y3 == 3'd7) &&
               ((!rd6 && ((x5 == 5'd17) || (x5 == 5'd18) || (x5 == 5'd20))) ||
                ( rd6 && ((x5 == 5'd11) || (x5 == 5'd13) || (x5 == 5'd14))));
        if (src_k) begin
            c4 = enc4_k(y3);
        end else if (alt7) begin
            c4 = 4'b0111;
        end else begin
            c4 = enc4_d(y3);
        end
        unbal4 = ($countones(c4) != 2);
        if (rd6 && (src_k || unbal4 || (y3 == 3'd3))) begin
            c4 = ~c4;
        end
        rd_sym = rd6 ^ unbal4;

        sym_msb = {c6, c4};
        for (int i = 0; i < 10; i++) begin
            sym[i] = sym_msb[9-i];
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
`ifdef SER_PRBS7_EN
    assign prbs_fb = prbs_q[6] ^ prbs_q[5];
`endif

    always_comb begin
        ser_d     = shift_q[0];
        shift_d   = {1'b0, shift_q[8:1]};
        bit_cnt_d = bit_cnt_q + CntW'(1);
        start_d   = 1'b0;
        err_d     = 1'b0;
        rd_d      = rd_q;
`ifdef SER_PRBS7_EN
        prbs_d    = prbs_q;
`endif
        if (boundary) begin
            ser_d     = sym[0];
            shift_d   = sym[9:1];
            bit_cnt_d = '0;
            start_d   = 1'b1;
            err_d     = bad_k;
            rd_d      = rd_sym;
        end
`ifdef SER_PRBS7_EN
        // The shift register is flushed so a mid-symbol exit sends zeros
        // until the next boundary reloads it.
        if (prbs_mode) begin
            ser_d   = prbs_fb;
            prbs_d  = {prbs_q[5:0], prbs_fb};
            shift_d = '0;
            start_d = 1'b0;
            err_d   = 1'b0;
            rd_d    = rd_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= LastBit;
            shift_q   <= '0;
            ser_q     <= 1'b0;
            start_q   <= 1'b0;
            rd_q      <= 1'b0;
            err_q     <= 1'b0;
`ifdef SER_PRBS7_EN
            prbs_q    <= 7'h7F;
`endif
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ser_q     <= ser_d;
            start_q   <= start_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
`ifdef SER_PRBS7_EN
            prbs_q    <= prbs_d;
`endif
        end
    end

    assign ser_out   = ser_q;
    assign sym_start = start_q;
    assign rd_out    = rd_q;
    assign code_err  = err_q;

endmodule

// File: tb/tb_ser_8b10b_tx.sv
// ---------------------------------------------------------------------------
// tb_ser_8b10b_tx
//
// Scoreboard bench for ser_8b10b_tx. The driver pushes the hand-computed
// symbol, running disparity and code_err expected for every symbol boundary.
// The monitor pops an entry at each sym_start, deserializes ten bits (bit 'a'
// first) and compares them. It also checks the 10-cycle in_ready spacing.
// ---------------------------------------------------------------------------
module tb_ser_8b10b_tx;

    typedef struct packed {
        logic [9:0] sym;  // written a..j, left to right
        logic       rd;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_8b = 8'h00;
    logic       in_k = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       ser_out;
    logic       sym_start;
    logic       rd_out;
    logic       code_err;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    logic mon_on = 1'b1;
    logic collecting = 1'b0;

    always #5 clk = ~clk;

    ser_8b10b_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_8b     (in_8b),
        .in_k      (in_k),
        .in_valid  (in_valid),
`ifdef SER_PRBS7_EN
        .prbs_mode (1'b0),
`endif
        .in_ready  (in_ready),
        .ser_out   (ser_out),
        .sym_start (sym_start),
        .rd_out    (rd_out),
        .code_err  (code_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, req, $time);
        end
    endtask

    // Wait for the boundary, present the word (or drop valid for fill) and
    // record what must come out for this boundary.
    task automatic offer(input logic v, input logic [7:0] b, input logic k,
                         input logic [9:0] s, input logic r, input logic e);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_at_boundary", 32'(in_ready), 32'd1);
        in_valid = v;
        in_8b    = b;
        in_k     = k;
        exp_q.push_back('{sym: s, rd: r, err: e});
        @(posedge clk);
        #1;
    endtask

    // Monitor
    initial begin
        exp_t       cur;
        logic       have_exp = 1'b0;
        logic [9:0] rx = '0;
        int         nbits = 0;
        int         cyc = 0;
        int         last_rdy = -1;
        forever begin
            @(negedge clk);
            if (!mon_on) begin
                continue;
            end
            if (!rst_n) begin
                collecting = 1'b0;
                last_rdy   = -1;
                continue;
            end
            cyc++;
            if (in_ready) begin
                if (last_rdy >= 0) begin
                    chk("in_ready_spacing", 32'(cyc - last_rdy), 32'd10);
                end
                last_rdy = cyc;
            end
            if (sym_start) begin
                if (exp_q.size() == 0) begin
                    chk("symbol_expected", 32'd0, 32'd1);
                    have_exp = 1'b0;
                end else begin
                    cur      = exp_q.pop_front();
                    have_exp = 1'b1;
                    chk("rd_out", 32'(rd_out), 32'(cur.rd));
                    chk("code_err_pulse", 32'(code_err), 32'(cur.err));
                end
                collecting = 1'b1;
                rx         = {9'b0, ser_out};
                nbits      = 1;
            end else begin
                chk("code_err_idle", 32'(code_err), 32'd0);
                if (collecting) begin
                    rx = {rx[8:0], ser_out};
                    nbits++;
                    if (nbits == 10) begin
                        collecting = 1'b0;
                        if (have_exp) begin
                            chk("symbol", 32'(rx), 32'(cur.sym));
                        end
                    end
                end
            end
        end
    end

    // Driver
    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ser_out", 32'(ser_out), 32'd0);
        chk("reset_sym_start", 32'(sym_start), 32'd0);
        chk("reset_rd_out", 32'(rd_out), 32'd0);
        chk("reset_code_err", 32'(code_err), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b1;
        #1;

        // Idle fill alternates K28.5 RD- / RD+
        offer(1'b0, 8'h00, 1'b0, 10'b0011111010, 1'b1, 1'b0);
        offer(1'b0, 8'h00, 1'b0, 10'b1100000101, 1'b0, 1'b0);
        offer(1'b0, 8'h00, 1'b0, 10'b0011111010, 1'b1, 1'b0);
        offer(1'b0, 8'h00, 1'b0, 10'b1100000101, 1'b0, 1'b0);
        // D0.0, D21.5 at RD-
        offer(1'b1, 8'h00, 1'b0, 10'b1001110100, 1'b0, 1'b0);
        offer(1'b1, 8'hB5, 1'b0, 10'b1010101010, 1'b0, 1'b0);
        // Back-to-back with valid held: D0.0, D21.5, K28.5
        offer(1'b1, 8'h00, 1'b0, 10'b1001110100, 1'b0, 1'b0);
        offer(1'b1, 8'hB5, 1'b0, 10'b1010101010, 1'b0, 1'b0);
        offer(1'b1, 8'hBC, 1'b1, 10'b0011111010, 1'b1, 1'b0);
        offer(1'b0, 8'h00, 1'b0, 10'b1100000101, 1'b0, 1'b0);
        // Invalid K (K0.0) at RD- and RD+ -> K28.5 with code_err
        offer(1'b1, 8'h00, 1'b1, 10'b0011111010, 1'b1, 1'b1);
        offer(1'b1, 8'h00, 1'b1, 10'b1100000101, 1'b0, 1'b1);
        // K28.0, K23.7 at RD-
        offer(1'b1, 8'h1C, 1'b1, 10'b0011110100, 1'b0, 1'b0);
        offer(1'b1, 8'hF7, 1'b1, 10'b1110101000, 1'b0, 1'b0);
        // D17.7 (A7 at RD-), D11.7 (A7 at RD+)
        offer(1'b1, 8'hF1, 1'b0, 10'b1000110111, 1'b1, 1'b0);
        offer(1'b1, 8'hEB, 1'b0, 10'b1101001000, 1'b0, 1'b0);
        // D7.3 at RD-, fill, D7.3 at RD+
        offer(1'b1, 8'h67, 1'b0, 10'b1110001100, 1'b0, 1'b0);
        offer(1'b0, 8'h00, 1'b0, 10'b0011111010, 1'b1, 1'b0);
        offer(1'b1, 8'h67, 1'b0, 10'b0001110011, 1'b1, 1'b0);
        offer(1'b0, 8'h00, 1'b0, 10'b1100000101, 1'b0, 1'b0);
        // D0.7 (primary P7) at RD-
        offer(1'b1, 8'hE0, 1'b0, 10'b1001110001, 1'b0, 1'b0);

        // Reset in the middle of D21.5 (bit_cnt = 4)
        offer(1'b1, 8'hB5, 1'b0, 10'b1010101010, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ser_out", 32'(ser_out), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_rd_out", 32'(rd_out), 32'd0);
        chk("midrst_sym_start", 32'(sym_start), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        offer(1'b0, 8'h00, 1'b0, 10'b0011111010, 1'b1, 1'b0);
        // D0.0 at RD+, then fill
        offer(1'b1, 8'h00, 1'b0, 10'b0110001011, 1'b1, 1'b0);
        offer(1'b0, 8'h00, 1'b0, 10'b1100000101, 1'b0, 1'b0);

        // Let the last symbol finish, then stop the monitor before the
        // next (unscored) boundary.
        repeat (9) @(posedge clk);
        @(negedge clk);
        #1 mon_on = 1'b0;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("symbol_complete", 32'(collecting), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ser_8b10b_tx.md
Name: ser_8b10b_tx

Overview:
- Transmit-side partner to the deserializer path.
- Accepts 8-bit data or control characters on a valid/ready handshake and 8b/10b encodes them with running disparity (IEEE 802.3 cl.36 tables).
- Shifts each 10-bit symbol out serially, one bit per clock, so the stream feeds the receiver's 10b word input.
- Link never idles: when no word is offered at a symbol boundary, the comma K28.5 is sent as fill.

Parameters:
- IDLE_K, 8'hBC, control character sent as fill when no word is accepted (must be a valid K code; default K28.5).
- SYM_W, 10, symbol width in bits; fixed at 10, exposed only for counter sizing.

Ports:
- clk  input  1  transmit bit clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_8b  input  8  data byte HGFEDCBA.
- in_k  input  1  1 = in_8b is a control (K) character.
- in_valid  input  1  word offered.
- in_ready  output  1  word accepted this cycle when in_valid & in_ready.
- ser_out  output  1  serial line, bit a of each symbol first.
- sym_start  output  1  high during the cycle ser_out carries bit a of a symbol.
- rd_out  output  1  current running disparity (0 = RD-, 1 = RD+).
- code_err  output  1  one-cycle pulse: accepted K code was invalid.

Behaviour:
- Reset (async assert, sync release):
  - bit_cnt = 9; shift_reg = 0; RD = RD-.
  - ser_out = 0, sym_start = 0, rd_out = 0, code_err = 0.
  - in_ready is forced 0 while rst_n is low.
- in_ready = rst_n & (bit_cnt == 9). It is combinational and high for exactly 1 cycle in every 10.
- Boundary edge (bit_cnt == 9):
  - Select the symbol source: the accepted word if in_valid & in_ready, else IDLE_K with K = 1.
  - Encode the symbol with the current RD.
  - ser_out <= sym[0] (bit a); shift_reg <= sym[9:1]; bit_cnt <= 0; sym_start <= 1.
  - RD <= disparity after the full symbol (6b sub-block RD feeds 4b selection, per standard).
- Other edges:
  - ser_out <= shift_reg[0]; shift right; bit_cnt++; sym_start <= 0.
- Latency: word accepted at edge E → bit a on ser_out after E; bit j after E+9.
- Back-to-back valid words are transmitted with no gap.
- in_valid low at a boundary → fill symbol. No data is lost; the upstream holds the word until in_ready.
- Encoder rules:
  - 5b/6b then 3b/4b, symbol bit order abcdei fghj.
  - D.x.7 uses the alternate A7 coding when (RD- & x ∈ {17,18,20}) or (RD+ & x ∈ {11,13,14}).
- Valid K codes: K28.0–K28.7, K23.7, K27.7, K29.7, K30.7.
- Any other K input is accepted (handshake completes), but K28.5 is transmitted instead and code_err pulses for 1 cycle, aligned with sym_start.
- rd_out is registered and changes on boundary edges only.
- Reset mid-symbol: the partial symbol is abandoned and RD returns to RD-. The first symbol after release is loaded on the first edge.
- Because bit_cnt = 9 at release, an in_valid already high at release is accepted on the first edge.

Optional Feature:
- SER_PRBS7_EN defined:
  - Adds input prbs_mode (1 bit).
  - When prbs_mode = 1, ser_out carries raw PRBS7 (x^7+x^6+1, seed 7'h7F, reset to seed) and bypasses the encoder.
  - in_ready is held 0, sym_start is 0, and RD is frozen.
  - Leaving PRBS mode resumes at the next bit_cnt == 9 boundary; bit_cnt keeps counting during PRBS mode.
- Not defined: port absent, no PRBS logic, and behaviour is exactly as above.

Test Plan:
- Reset release, in_valid = 0 for 40 cycles → ser_out repeats 0011111010 (RD-) and 1100000101 (RD+) alternately; sym_start every 10th cycle; rd_out toggles each symbol.
- RD-, offer 8'h00 k = 0 at first boundary → ser_out 1001110100, rd_out stays 0.
- RD-, offer 8'hB5 (D21.5) → 1010101010, RD unchanged; in_ready was high exactly at bit_cnt = 9.
- Hold in_valid with 3 words (00, B5, BC with k = 1) → three consecutive symbols with no fill between; in_ready high 3 times, 10 cycles apart.
- Offer 8'h00 with k = 1 → handshake completes, code_err pulse with sym_start, K28.5 for the current RD transmitted.
- Assert rst_n low at bit_cnt = 4 mid-D21.5 → ser_out = 0 and in_ready = 0 immediately; after release the stream restarts with RD- K28.5 0011111010.
